// File: rtl/song_sequencer_pkg.sv
// Shared types for the song sequencer: FSM state encoding and the song ROM word layout.
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_END   = 3'd4
  } state_e;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int ROM_W  = NOTE_W + DUR_W;

  // ROM word is {note[11:6], duration[5:0]}; duration 0 marks end of song.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

  function automatic rom_word_t mk_word(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
    rom_word_t w;
    w.note = n;
    w.dur  = d;
    return w;
  endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Registered song ROM (one cycle read latency), addressed by {song, note index}.
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter int SONG_IDX_W = 2,
  parameter int NOTE_IDX_W = 5
) (
  input  logic                             clk,
  input  logic [SONG_IDX_W+NOTE_IDX_W-1:0] addr,
  output rom_word_t                        data
);

  localparam int ADDR_W = SONG_IDX_W + NOTE_IDX_W;

  rom_word_t word;
  int        sn;
  int        sl;

  // Song 3 fills every slot so that playback ends on the last index, not a marker.
  always_comb begin
    word = '0;
    sn   = int'(addr[ADDR_W-1 -: SONG_IDX_W]);
    sl   = int'(addr[NOTE_IDX_W-1:0]);
    case (sn)
      0: case (sl)
           0:       word = mk_word(6'd20, 6'd3);
           1:       word = mk_word(6'd0,  6'd2);
           default: word = '0;
         endcase
      1: case (sl)
           0:       word = mk_word(6'd10, 6'd4);
           1:       word = mk_word(6'd11, 6'd5);
           2:       word = mk_word(6'd12, 6'd6);
           default: word = '0;
         endcase
      2: case (sl)
           0:       word = mk_word(6'd30, 6'd1);
           1:       word = mk_word(6'd31, 6'd2);
           default: word = '0;
         endcase
      3:       word = mk_word(6'(sl + 1), 6'((sl % 7) + 1));
      default: word = '0;
    endcase
  end

  always_ff @(posedge clk) data <= word;

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM note by note, handing each note to the note player.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int SONG_IDX_W = 2,
  parameter int NOTE_IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic [SONG_IDX_W-1:0] song,
  input  logic                  done_with_note,
  output logic [NOTE_W-1:0]     note_to_load,
  output logic [DUR_W-1:0]      duration_to_load,
  output logic                  load_new_note,
  output logic                  play_enable,
  output logic                  song_done
);

  localparam logic [NOTE_IDX_W-1:0] LAST_IDX = '1;

  state_e                  state, state_n;
  logic                    play_q;
  logic [SONG_IDX_W-1:0]   song_q;
  logic [NOTE_IDX_W-1:0]   idx;
  rom_word_t               rom_q;
  logic                    start, song_ld, idx_clr, idx_inc, note_ld;

  assign start = play & ~play_q;

  song_rom #(
    .SONG_IDX_W(SONG_IDX_W),
    .NOTE_IDX_W(NOTE_IDX_W)
  ) u_rom (
    .clk  (clk),
    .addr ({song_q, idx}),
    .data (rom_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    song_ld     = 1'b0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    note_ld     = 1'b0;
    play_enable = 1'b0;
    song_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          song_ld = 1'b1;
          idx_clr = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        play_enable = play;
        if (play) state_n = S_LOAD;
      end
      // ROM word stays valid while paused here since the address does not move.
      S_LOAD: begin
        play_enable = play;
        if (play) begin
          if (rom_q.dur == '0) begin
            state_n = S_END;
          end else begin
            note_ld = 1'b1;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        play_enable = play;
        if (play && done_with_note) begin
          if (idx == LAST_IDX) begin
            state_n = S_END;
          end else begin
            idx_inc = 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_END: begin
        song_done = 1'b1;
        idx_clr   = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      play_q           <= 1'b0;
      song_q           <= '0;
      idx              <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      load_new_note    <= 1'b0;
    end else begin
      play_q        <= play;
      load_new_note <= note_ld;
      if (song_ld) song_q <= song;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + NOTE_IDX_W'(1);
      if (note_ld) begin
        note_to_load     <= rom_q.note;
        duration_to_load <= rom_q.dur;
      end
    end
  end

endmodule
